// File: rtl/cmatmul_pkg.sv
// Shared definitions for the 4x4 complex matrix multiplier.
// Provides the default component width, the matrix dimension and the
// full-precision output width helper.
package cmatmul_pkg;

   localparam int unsigned W_DEFAULT = 4;
   localparam int unsigned N         = 4;

   // 2w bits per product, +1 for the add/sub, +2 for the 4-term sum
   function automatic int unsigned out_width(input int unsigned w);
      return 2 * w + 3;
   endfunction

endpackage

// File: rtl/complex_matmul_4x4_if.sv
// Operand/result bundle for complex_matmul_4x4.
// master: drives in_valid, A_real/A_imag, B_real/B_imag; observes out_valid, C_real/C_imag.
// slave : the multiplier side (inverse directions).
interface complex_matmul_4x4_if
   import cmatmul_pkg::*;
#(
   parameter int unsigned w = W_DEFAULT
);
   localparam int unsigned WIDTH_OUT = out_width(w);

   logic                        in_valid;
   logic signed [w-1:0]         A_real [0:N-1][0:N-1];
   logic signed [w-1:0]         A_imag [0:N-1][0:N-1];
   logic signed [w-1:0]         B_real [0:N-1][0:N-1];
   logic signed [w-1:0]         B_imag [0:N-1][0:N-1];
   logic                        out_valid;
   logic signed [WIDTH_OUT-1:0] C_real [0:N-1][0:N-1];
   logic signed [WIDTH_OUT-1:0] C_imag [0:N-1][0:N-1];

   modport master (
      output in_valid, A_real, A_imag, B_real, B_imag,
      input  out_valid, C_real, C_imag
   );

   modport slave (
      input  in_valid, A_real, A_imag, B_real, B_imag,
      output out_valid, C_real, C_imag
   );

endinterface

// File: rtl/cdot4_complex.sv
// Combinational complex dot product of one row of A with one column of B.
// Ports: a_real/a_imag (row), b_real/b_imag (column), c_real/c_imag (exact sum).
module cdot4_complex
   import cmatmul_pkg::*;
#(
   parameter int unsigned w = W_DEFAULT
) (
   input  logic signed [w-1:0]              a_real [0:N-1],
   input  logic signed [w-1:0]              a_imag [0:N-1],
   input  logic signed [w-1:0]              b_real [0:N-1],
   input  logic signed [w-1:0]              b_imag [0:N-1],
   output logic signed [out_width(w)-1:0]   c_real,
   output logic signed [out_width(w)-1:0]   c_imag
);
   localparam int unsigned WIDTH_OUT = out_width(w);
   localparam int unsigned PW        = 2 * w;

   logic signed [PW-1:0] p_rr [0:N-1];
   logic signed [PW-1:0] p_ii [0:N-1];
   logic signed [PW-1:0] p_ri [0:N-1];
   logic signed [PW-1:0] p_ir [0:N-1];

   // Operands widened before multiplying so each product is exact
   for (genvar k = 0; k < N; k++) begin : g_term
      assign p_rr[k] = PW'(a_real[k]) * PW'(b_real[k]);
      assign p_ii[k] = PW'(a_imag[k]) * PW'(b_imag[k]);
      assign p_ri[k] = PW'(a_real[k]) * PW'(b_imag[k]);
      assign p_ir[k] = PW'(a_imag[k]) * PW'(b_real[k]);
   end

   // Sign-extend every partial product before the accumulation
   always_comb begin
      c_real = '0;
      c_imag = '0;
      for (int k = 0; k < N; k++) begin
         c_real = c_real + WIDTH_OUT'(p_rr[k]) - WIDTH_OUT'(p_ii[k]);
         c_imag = c_imag + WIDTH_OUT'(p_ri[k]) + WIDTH_OUT'(p_ir[k]);
      end
   end

endmodule

// File: rtl/complex_matmul_4x4.sv
// Registered 4x4 complex matrix multiplier C = A*B (schoolbook, exact).
// Ports: clk, rst_n (async active-low), bus (slave side of complex_matmul_4x4_if).
// One-cycle latency, one matrix pair per cycle, C holds when in_valid is low.
module complex_matmul_4x4
   import cmatmul_pkg::*;
#(
   parameter int unsigned w = W_DEFAULT
) (
   input logic                  clk,
   input logic                  rst_n,
   complex_matmul_4x4_if.slave  bus
);
   localparam int unsigned WIDTH_OUT = out_width(w);

   logic signed [WIDTH_OUT-1:0] c_real_c [0:N-1][0:N-1];
   logic signed [WIDTH_OUT-1:0] c_imag_c [0:N-1][0:N-1];

   // One dot-product unit per output element
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [w-1:0] a_row_real [0:N-1];
         logic signed [w-1:0] a_row_imag [0:N-1];
         logic signed [w-1:0] b_col_real [0:N-1];
         logic signed [w-1:0] b_col_imag [0:N-1];

         for (genvar k = 0; k < N; k++) begin : g_sel
            assign a_row_real[k] = bus.A_real[i][k];
            assign a_row_imag[k] = bus.A_imag[i][k];
            assign b_col_real[k] = bus.B_real[k][j];
            assign b_col_imag[k] = bus.B_imag[k][j];
         end

         cdot4_complex #(.w(w)) u_dot (
            .a_real (a_row_real),
            .a_imag (a_row_imag),
            .b_real (b_col_real),
            .b_imag (b_col_imag),
            .c_real (c_real_c[i][j]),
            .c_imag (c_imag_c[i][j])
         );
      end
   end

   // Result registers: load on in_valid, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               bus.C_real[i][j] <= '0;
               bus.C_imag[i][j] <= '0;
            end
         end
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  bus.C_real[i][j] <= c_real_c[i][j];
                  bus.C_imag[i][j] <= c_imag_c[i][j];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_complex_matmul_4x4.sv
// Directed and random checks of complex_matmul_4x4 at w=4 (11-bit outputs).
module tb_complex_matmul_4x4;

   localparam int unsigned W  = 4;
   localparam int unsigned WO = 11;
   localparam int unsigned FW = 32 * WO;

   typedef logic signed [W-1:0] mat_t [0:3][0:3];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   complex_matmul_4x4_if #(.w(W)) bus ();

   complex_matmul_4x4 #(.w(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Golden model: 128-bit signed accumulation, then the low 11 bits.
   // Flat layout: element e=i*4+j, real at [e*22 +: 11], imag at [e*22+11 +: 11].
   function automatic logic [FW-1:0] golden(input mat_t ar, input mat_t ai,
                                            input mat_t br, input mat_t bi);
      logic [FW-1:0]     r;
      logic signed [127:0] sr;
      logic signed [127:0] si;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            sr = '0;
            si = '0;
            for (int k = 0; k < 4; k++) begin
               sr = sr + 128'(ar[i][k]) * 128'(br[k][j]) - 128'(ai[i][k]) * 128'(bi[k][j]);
               si = si + 128'(ar[i][k]) * 128'(bi[k][j]) + 128'(ai[i][k]) * 128'(br[k][j]);
            end
            r[(i*4+j)*22 +: 11]      = sr[10:0];
            r[(i*4+j)*22 + 11 +: 11] = si[10:0];
         end
      end
      return r;
   endfunction

   function automatic logic [FW-1:0] const_flat(input int re, input int im);
      logic [FW-1:0] r;
      logic [31:0]   vr;
      logic [31:0]   vi;
      vr = re;
      vi = im;
      r  = '0;
      for (int e = 0; e < 16; e++) begin
         r[e*22 +: 11]      = vr[10:0];
         r[e*22 + 11 +: 11] = vi[10:0];
      end
      return r;
   endfunction

   function automatic logic [FW-1:0] observed();
      logic [FW-1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            r[(i*4+j)*22 +: 11]      = bus.C_real[i][j];
            r[(i*4+j)*22 + 11 +: 11] = bus.C_imag[i][j];
         end
      end
      return r;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = 4'($urandom);
      return m;
   endfunction

   function automatic mat_t fill_mat(input logic signed [W-1:0] v);
      mat_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = v;
      return m;
   endfunction

   task automatic drive(input logic v, input mat_t ar, input mat_t ai,
                        input mat_t br, input mat_t bi);
      bus.in_valid = v;
      bus.A_real   = ar;
      bus.A_imag   = ai;
      bus.B_real   = br;
      bus.B_imag   = bi;
   endtask

   task automatic drive_idle();
      mat_t xm;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            xm[i][j] = 'x;
      drive(1'b0, xm, xm, xm, xm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [FW-1:0] obs;
      drive_idle();
      #3;
      checks++;
      obs = observed();
      if (obs !== '0 || bus.out_valid !== 1'b0)
         $display("FAIL reset_initial: C=%h out_valid=%b expected zero/0", obs, bus.out_valid);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(-4'sd8));
      step();
      drive_idle();
      checks++;
      obs = observed();
      if (obs !== const_flat(0, 512))
         $display("FAIL reset_preload: C=%h expected %h", obs, const_flat(0, 512));
      else passed++;
      // Async reset mid-cycle, no clock edge in between
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      obs = observed();
      if (obs !== '0)
         $display("FAIL reset_async_c: C=%h expected 0", obs);
      else passed++;
      checks++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL reset_async_valid: out_valid=%b expected 0", bus.out_valid);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || observed() !== '0)
         $display("FAIL reset_release_idle: out_valid=%b C=%h expected 0/zero", bus.out_valid, observed());
      else passed++;
   endtask

   task automatic test_identity();
      mat_t ar, ai, br, bi;
      logic [FW-1:0] exp_c;
      logic [FW-1:0] obs;
      ar = fill_mat(4'sd0);
      ai = fill_mat(4'sd0);
      for (int d = 0; d < 4; d++) ar[d][d] = 4'sd1;
      br = rand_mat();
      bi = rand_mat();
      br[0][0] = -4'sd8;
      bi[3][3] = 4'sd7;
      exp_c = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            exp_c[(i*4+j)*22 +: 11]      = 11'(br[i][j]);
            exp_c[(i*4+j)*22 + 11 +: 11] = 11'(bi[i][j]);
         end
      end
      drive(1'b1, ar, ai, br, bi);
      step();
      drive_idle();
      checks++;
      obs = observed();
      if (obs !== exp_c)
         $display("FAIL identity: C=%h expected %h", obs, exp_c);
      else passed++;
      checks++;
      if (bus.out_valid !== 1'b1)
         $display("FAIL identity_valid: out_valid=%b expected 1", bus.out_valid);
      else passed++;
   endtask

   task automatic test_min_value();
      logic [FW-1:0] obs;
      drive(1'b1, fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(-4'sd8));
      step();
      drive_idle();
      checks++;
      obs = observed();
      if (obs !== const_flat(0, 512))
         $display("FAIL min_value: C=%h expected %h", obs, const_flat(0, 512));
      else passed++;
   endtask

   task automatic test_extreme();
      logic [FW-1:0] obs;
      // (-8-8i)(-8+7i) = 120+8i per term, four terms
      drive(1'b1, fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(-4'sd8), fill_mat(4'sd7));
      step();
      drive_idle();
      checks++;
      obs = observed();
      if (obs !== const_flat(480, 32))
         $display("FAIL extreme: C=%h expected %h", obs, const_flat(480, 32));
      else passed++;
   endtask

   task automatic test_back_to_back();
      mat_t ar, ai, br, bi;
      logic [FW-1:0] exp_c;
      logic [FW-1:0] obs;
      exp_c = '0;
      for (int p = 0; p < 3; p++) begin
         ar = rand_mat(); ai = rand_mat(); br = rand_mat(); bi = rand_mat();
         exp_c = golden(ar, ai, br, bi);
         drive(1'b1, ar, ai, br, bi);
         step();
         checks++;
         obs = observed();
         if (obs !== exp_c || bus.out_valid !== 1'b1)
            $display("FAIL b2b_pair%0d: C=%h out_valid=%b expected %h/1", p, obs, bus.out_valid, exp_c);
         else passed++;
      end
      drive_idle();
      for (int h = 0; h < 2; h++) begin
         step();
         checks++;
         obs = observed();
         if (obs !== exp_c)
            $display("FAIL b2b_hold%0d: C=%h expected %h", h, obs, exp_c);
         else passed++;
         checks++;
         if (bus.out_valid !== 1'b0)
            $display("FAIL b2b_valid_drop%0d: out_valid=%b expected 0", h, bus.out_valid);
         else passed++;
      end
   endtask

   task automatic test_random();
      mat_t ar, ai, br, bi;
      logic [FW-1:0] exp_c;
      logic [FW-1:0] obs;
      logic          v;
      exp_c = '0;
      for (int n = 0; n < 3300; n++) begin
         v = (n == 0) || ($urandom_range(7) != 0);
         if (v) begin
            ar = rand_mat(); ai = rand_mat(); br = rand_mat(); bi = rand_mat();
            exp_c = golden(ar, ai, br, bi);
            drive(1'b1, ar, ai, br, bi);
         end else begin
            drive_idle();
         end
         step();
         checks++;
         obs = observed();
         if (obs !== exp_c)
            $display("FAIL random_c n=%0d: C=%h expected %h", n, obs, exp_c);
         else passed++;
         checks++;
         if (bus.out_valid !== v)
            $display("FAIL random_valid n=%0d: out_valid=%b expected %b", n, bus.out_valid, v);
         else passed++;
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_identity();
      test_min_value();
      test_extreme();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
